// File: rtl/uart_frame_pkg.sv
// Shared constants, state encodings and checksum helper for the UART telemetry frame arbiter.
package uart_frame_pkg;

  localparam logic [7:0]  HEADER_DEFAULT  = 8'hBB;
  localparam logic [7:0]  TRAILER_DEFAULT = 8'hAA;
  localparam int unsigned FRAME_LEN       = 10;
  localparam int unsigned PAYLOAD_BYTES   = 6;
  localparam int unsigned PAYLOAD_W       = 8 * PAYLOAD_BYTES;
  localparam int unsigned MAX_REQ         = 16;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned CAND_W          = IDX_W + 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_DV        = 3'd2;
  localparam logic [2:0] ST_GUARD1    = 3'd3;
  localparam logic [2:0] ST_GUARD2    = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  // XOR of the channel ID and all six payload bytes.
  function automatic logic [7:0] frame_checksum(input logic [7:0] id,
                                                input logic [PAYLOAD_W-1:0] payload);
    logic [7:0] c;
    c = id;
    for (int unsigned b = 0; b < PAYLOAD_BYTES; b++) begin
      c = c ^ payload[8*b +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, with wrap.
module rr_arbiter
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic [CAND_W-1:0]  cand;

  always_comb begin
    req_ext     = MAX_REQ'(req);
    cand        = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = CAND_W'(ptr) + CAND_W'(off);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!grant_valid && req_ext[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
    grant = grant_valid ? NUM_REQ'(MAX_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin telemetry framer: grants one requester, snapshots its payload and
// paces a 10-byte frame into a UART TX core over the DV/Active handshake.
module uart_tx_frame_arbiter
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
  parameter logic [7:0]  TRAILER = TRAILER_DEFAULT
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic [NUM_REQ-1:0]             i_Req,
  input  logic [PAYLOAD_W*NUM_REQ-1:0]   i_Payload,
  output logic [NUM_REQ-1:0]             o_Ack,
  output logic                           o_Busy,
  output logic                           o_TX_DV,
  output logic [7:0]                     o_TX_Byte,
  input  logic                           i_TX_Active
);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("uart_tx_frame_arbiter: NUM_REQ must be in 1..16");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [7:0]           id_q, id_d;
  logic [7:0]           csum_q, csum_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [PAYLOAD_W-1:0] payload_sel;
  logic [7:0]           grant_id;
  logic [7:0]           frame_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req         (i_Req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // One-hot payload mux driven by the arbiter grant.
  always_comb begin
    payload_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) payload_sel = payload_sel | i_Payload[PAYLOAD_W*k +: PAYLOAD_W];
    end
    grant_id = {4'h0, grant_idx};
  end

  always_comb begin
    case (idx_q)
      4'd0:    frame_byte = HEADER;
      4'd1:    frame_byte = id_q;
      4'd2:    frame_byte = payload_q[7:0];
      4'd3:    frame_byte = payload_q[15:8];
      4'd4:    frame_byte = payload_q[23:16];
      4'd5:    frame_byte = payload_q[31:24];
      4'd6:    frame_byte = payload_q[39:32];
      4'd7:    frame_byte = payload_q[47:40];
      4'd8:    frame_byte = csum_q;
      4'd9:    frame_byte = TRAILER;
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    payload_d = payload_q;
    id_d      = id_q;
    csum_d    = csum_q;
    ack_d     = '0;
    busy_d    = busy_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !i_TX_Active) begin
          payload_d = payload_sel;
          id_d      = grant_id;
          csum_d    = frame_checksum(grant_id, payload_sel);
          ack_d     = grant;
          busy_d    = 1'b1;
          ptr_d     = (grant_idx == LAST_REQ) ? '0 : IDX_W'(grant_idx + IDX_W'(1));
          idx_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_byte_d = frame_byte;
        state_d   = ST_DV;
      end
      ST_DV: begin
        tx_dv_d = 1'b1;
        state_d = ST_GUARD1;
      end
      // Guard cycles give the UART time to raise Active after the DV pulse.
      ST_GUARD1: state_d = ST_GUARD2;
      ST_GUARD2: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!i_TX_Active) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = IDX_W'(idx_q + IDX_W'(1));
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      payload_q <= '0;
      id_q      <= '0;
      csum_q    <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      csum_q    <= csum_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Ack     = ack_q;
  assign o_Busy    = busy_q;
  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Scoreboard bench for uart_tx_frame_arbiter: expected grants and frame bytes are
// queued as requests are driven and compared as the DUT acks and pulses DV.
module tb_uart_tx_frame_arbiter;

  localparam int unsigned NREQ = 4;

  logic            i_Clk = 1'b0;
  logic            i_Rst = 1'b1;
  logic [NREQ-1:0] i_Req = '0;
  logic [47:0]     pay [NREQ];
  logic [NREQ-1:0] o_Ack;
  logic            o_Busy;
  logic            o_TX_DV;
  logic [7:0]      o_TX_Byte;
  logic            uart_act = 1'b0;
  logic            hold_act = 1'b0;
  logic            i_TX_Active;

  assign i_TX_Active = uart_act | hold_act;

  uart_tx_frame_arbiter #(.NUM_REQ(NREQ)) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Req       (i_Req),
    .i_Payload   ({pay[3], pay[2], pay[1], pay[0]}),
    .o_Ack       (o_Ack),
    .o_Busy      (o_Busy),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         uart_delay = 0;
  int         ucnt = 0;
  int         dv_cnt = 0;
  int         ack_cyc = 0;
  logic       prev_dv = 1'b0;
  logic [7:0] byte_q [$];
  logic [3:0] ack_q [$];
  int         dv_cyc [$];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue one frame's worth of expected bytes from the bench's own frame model.
  task automatic expect_frame(input int ch, input logic [47:0] p);
    logic [7:0] id;
    logic [7:0] cs;
    id = 8'(ch);
    cs = id;
    byte_q.push_back(8'hBB);
    byte_q.push_back(id);
    for (int b = 0; b < 6; b++) begin
      byte_q.push_back(p[8*b +: 8]);
      cs = cs ^ p[8*b +: 8];
    end
    byte_q.push_back(cs);
    byte_q.push_back(8'hAA);
    ack_q.push_back(4'(1 << ch));
  endtask

  initial forever #5 i_Clk = ~i_Clk;
  initial forever begin @(posedge i_Clk); cyc++; end

  // UART model: Active rises after each DV and falls uart_delay cycles later.
  initial forever begin
    @(posedge i_Clk);
    #1;
    if (i_Rst) begin
      uart_act = 1'b0;
      ucnt = 0;
    end else if (o_TX_DV && uart_delay > 0) begin
      uart_act = 1'b1;
      ucnt = uart_delay;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) uart_act = 1'b0;
    end
  end

  // Output monitor / scoreboard compare.
  initial forever begin
    @(negedge i_Clk);
    if (!i_Rst) begin
      if (o_TX_DV) begin
        check_value("dv_not_back_to_back", 64'(prev_dv), 64'(0));
        check_value("busy_during_dv", 64'(o_Busy), 64'(1));
        if (byte_q.size() == 0) check_value("spurious_tx_byte", 64'(o_TX_Byte), 64'hDEAD);
        else check_value("tx_byte", 64'(o_TX_Byte), 64'(byte_q.pop_front()));
        dv_cnt++;
        dv_cyc.push_back(cyc);
      end
      if (|o_Ack) begin
        check_value("busy_with_ack", 64'(o_Busy), 64'(1));
        if (ack_q.size() == 0) check_value("spurious_ack", 64'(o_Ack), 64'(0));
        else check_value("ack_grant", 64'(o_Ack), 64'(ack_q.pop_front()));
        ack_cyc = cyc;
      end
    end
    prev_dv = o_TX_DV;
  end

  task automatic do_reset();
    @(negedge i_Clk);
    #1;
    i_Rst = 1'b1;
    i_Req = '0;
    byte_q.delete();
    ack_q.delete();
    @(negedge i_Clk);
    check_value("rst_ack", 64'(o_Ack), 64'(0));
    check_value("rst_busy", 64'(o_Busy), 64'(0));
    check_value("rst_tx_dv", 64'(o_TX_DV), 64'(0));
    check_value("rst_tx_byte", 64'(o_TX_Byte), 64'(0));
    i_Rst = 1'b0;
  endtask

  // Drive a request vector and wait for n acks; optionally drop each requester on its ack.
  task automatic run_reqs(input logic [NREQ-1:0] v, input int n, input bit clear_on_ack);
    int got;
    got = 0;
    i_Req = v;
    for (int i = 0; i < 3000 && got < n; i++) begin
      @(negedge i_Clk);
      if (|o_Ack) begin
        got++;
        if (clear_on_ack) i_Req = i_Req & ~o_Ack;
      end
    end
    i_Req = '0;
    if (got != n) check_value("ack_timeout", 64'(got), 64'(n));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge i_Clk);
      if (!o_Busy && byte_q.size() == 0) done = 1'b1;
    end
    if (!done) check_value("idle_timeout", 64'(byte_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    for (int k = 0; k < NREQ; k++) pay[k] = 48'h0;

    do_reset();

    // Single frame with literal expected bytes, slow UART.
    uart_delay = 20;
    pay[2] = 48'h0605_0403_0201;
    byte_q = '{8'hBB, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h05, 8'hAA};
    ack_q.push_back(4'b0100);
    run_reqs(4'b0100, 1, 1'b1);
    wait_idle();

    // Round robin with all requesters held, then 1001 with pointer at 1.
    do_reset();
    uart_delay = 3;
    pay[0] = 48'hA0A1_A2A3_A4A5;
    pay[1] = 48'h1111_2222_3333;
    pay[2] = 48'hFFFF_0000_FFFF;
    pay[3] = 48'h8000_0000_0001;
    expect_frame(0, pay[0]);
    expect_frame(1, pay[1]);
    expect_frame(2, pay[2]);
    expect_frame(3, pay[3]);
    expect_frame(0, pay[0]);
    run_reqs(4'b1111, 5, 1'b0);
    wait_idle();
    expect_frame(3, pay[3]);
    expect_frame(0, pay[0]);
    run_reqs(4'b1001, 2, 1'b1);
    wait_idle();

    // Zero-latency UART: 5 cycles per byte, 50 cycles busy.
    uart_delay = 0;
    pay[1] = 48'h0123_4567_89AB;
    expect_frame(1, pay[1]);
    dv_cyc.delete();
    run_reqs(4'b0010, 1, 1'b1);
    n = 0;
    for (int i = 0; i < 200 && o_Busy; i++) begin
      n++;
      @(negedge i_Clk);
    end
    check_value("busy_cycles_zero_latency", 64'(n), 64'(50));
    check_value("dv_count_zero_latency", 64'(dv_cyc.size()), 64'(10));
    if (dv_cyc.size() == 10) begin
      check_value("ack_to_first_dv", 64'(dv_cyc[0] - ack_cyc), 64'(2));
      for (int i = 1; i < 10; i++) check_value("dv_spacing", 64'(dv_cyc[i] - dv_cyc[i-1]), 64'(5));
    end
    wait_idle();

    // Payload altered one cycle after the ack must not reach the wire.
    uart_delay = 2;
    pay[0] = 48'hC0FF_EE12_3456;
    expect_frame(0, pay[0]);
    run_reqs(4'b0001, 1, 1'b1);
    @(negedge i_Clk);
    pay[0] = 48'h0BAD_0BAD_0BAD;
    wait_idle();

    // Reset in the middle of a frame, then a fresh frame from requester 1.
    pay[1] = 48'h5A5A_A5A5_3C3C;
    expect_frame(1, pay[1]);
    dv_cnt = 0;
    run_reqs(4'b0010, 1, 1'b1);
    for (int i = 0; i < 500 && dv_cnt < 4; i++) @(negedge i_Clk);
    check_value("mid_frame_dv_count", 64'(dv_cnt), 64'(4));
    do_reset();
    expect_frame(1, pay[1]);
    run_reqs(4'b0010, 1, 1'b1);
    wait_idle();

    // UART busy in idle: no grant until Active drops, then ack one cycle later.
    hold_act = 1'b1;
    i_Req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_Clk);
      check_value("ack_while_uart_busy", 64'(o_Ack), 64'(0));
    end
    expect_frame(0, pay[0]);
    hold_act = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !o_Ack[0]; i++) begin
      @(negedge i_Clk);
      n++;
    end
    i_Req = '0;
    check_value("ack_after_active_drop", 64'(n), 64'(1));
    wait_idle();

    repeat (5) @(negedge i_Clk);
    check_value("scoreboard_drained", 64'(byte_q.size() + ack_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_arbiter.md
# uart_tx_frame_arbiter

Shares one UART transmitter between several telemetry requesters (tick counter, PID error, set-point, output) on the PID board. Round-robin grants one requester at a time, snapshots its 48-bit payload, and emits a 10-byte frame: 0xBB, channel ID, six payload bytes LSB first, XOR checksum, 0xAA. Each byte is paced on the transmitter's DV/Active handshake. Sits between the PID datapath sources and the UART TX core.

## Interface
- NUM_REQ, 4: requester count, legal 1..16; elaboration error otherwise
- HEADER, 8'hBB: first frame byte
- TRAILER, 8'hAA: last frame byte
- i_Clk  in  1  sole clock, rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_Req  in  NUM_REQ  per-requester frame request, level, held until ack
- i_Payload  in  48*NUM_REQ  payload k at bits [48k+47:48k]
- o_Ack  out  NUM_REQ  one-cycle pulse: payload k latched, request consumed
- o_Busy  out  1  high from grant until trailer completes
- o_TX_DV  out  1  one-cycle byte-valid pulse to UART TX
- o_TX_Byte  out  8  byte to send, stable from one cycle before o_TX_DV until the next SEND
- i_TX_Active  in  1  UART TX busy flag

## Operation
- Reset values: o_Ack=0, o_Busy=0, o_TX_DV=0, o_TX_Byte=8'h00, state IDLE, byte index 0, RR pointer 0.
- States: IDLE, SEND, DV, GUARD1, GUARD2, WAIT_DONE.
- IDLE: if any i_Req and i_TX_Active==0 -> grant g = first requester with i_Req high, searching from pointer upward with wrap. Latch payload g and ID {4'h0,g}. Compute checksum = ID ^ payload bytes 0..5. Pulse o_Ack[g], set o_Busy, pointer <= (g+1) mod NUM_REQ, index <= 0, -> SEND. Otherwise stay.
- SEND: o_TX_Byte <= frame[index] -> DV.
- DV: o_TX_DV <= 1 -> GUARD1.
- GUARD1, GUARD2: o_TX_DV <= 0. i_TX_Active is ignored to cover UART start latency.
- WAIT_DONE: stay while i_TX_Active==1. When 0: if index==9, clear o_Busy -> IDLE; else index++ -> SEND.
- Frame order: index 0 HEADER, 1 ID, 2..7 payload[7:0]..payload[47:40], 8 checksum, 9 TRAILER.
- Payload changes after ack do not affect the frame in flight.
- Requests arriving during a frame wait. Requests dropped before grant are never served; no frame, no ack.
- All requesters high: strict rotation 0,1,2,3,0...
- NUM_REQ==1: pointer stays 0.

## Timing
- Request seen in IDLE at edge t: o_Ack/o_Busy high after edge t+1; first o_TX_DV after edge t+3.
- Per byte: SEND, DV, GUARD1, GUARD2, then WAIT_DONE for at least 1 cycle. Minimum 5 cycles per byte with an instantly-idle UART; frame minimum 50 cycles plus UART time.
- o_TX_DV is never high on two consecutive cycles. It is never asserted while in WAIT_DONE.
- After the trailer, IDLE may grant on the next cycle (back-to-back frames).
- i_Rst mid-frame: all outputs return to reset values on the next edge; frame abandoned; pointer to 0; no ack re-issued.
- i_TX_Active high in IDLE (UART owned elsewhere or still finishing): no grant until it is low.

## Structure
- Package uart_frame_pkg: HEADER/TRAILER defaults, FRAME_LEN=10, PAYLOAD_BYTES=6, state encodings.
- Sub-module rr_arbiter: NUM_REQ-wide request vector plus pointer in, one-hot grant and index out; purely combinational. The pointer register stays in the parent.
- Payload mux, checksum XOR, and byte-select mux stay in the parent.

## Test plan
- Single frame: i_Req[2]=1, payload 48'h0605_0403_0201, UART model deasserts Active 20 cycles after DV -> bytes BB,02,01,02,03,04,05,06,checksum 0x05,AA; one o_Ack[2] pulse.
- Round-robin: i_Req=4'b1111 held -> grant order 0,1,2,3,0. Then req 4'b1001 with pointer=1 -> grant 3, then 0.
- Zero-latency UART: Active never asserted -> each byte takes exactly 5 cycles, DV pulses 5 cycles apart, frame done in 50 cycles.
- Payload change after ack: alter i_Payload[0] one cycle after o_Ack[0] -> transmitted bytes match the snapshot.
- Reset during byte 4 of a frame -> next cycle o_TX_DV=0, o_Busy=0, o_TX_Byte=00. A new i_Req[1] then produces a full fresh frame starting with BB.
- Busy UART at idle: i_TX_Active=1 with i_Req[0]=1 -> no ack until Active drops; ack one cycle later.
